dmem_bus: RTL

Parametrised successor data memory for the 32-bit CPU: word-organised RAM behind a valid/ready request port with byte/half/word access, sign/zero extension, alignment and range checking, and configurable read latency. Sits between the CPU load/store stage and the word array; a registered tap byte feeds the board display logic.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_bus_if.sv | 35 +++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_bus.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the dmem_bus data memory.
//   SZ_*         access size encodings carried on req_size
//   state_t      FSM state word, S_IDLE / S_WAIT / S_RESP
//   LANE_EN_TBL  byte-lane enable table indexed [size][addr[1:0]]
//   lane_en()    lookup helper for LANE_EN_TBL
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_WAIT = 2'd1;
   localparam state_t S_RESP = 2'd2;

   // Row per size, nibble per byte offset. Misaligned half/word offsets
   // still return a mask; fault detection suppresses them upstream.
   // The reserved size enables no lanes.
   localparam logic [3:0][3:0][3:0] LANE_EN_TBL = {
      16'h0000,   // SZ_RSVD
      16'hFFFF,   // SZ_WORD
      16'hCC33,   // SZ_HALF: offsets 0/1 -> lanes 0-1, 2/3 -> lanes 2-3
      16'h8421    // SZ_BYTE: one lane per offset
   };

   function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
      return LANE_EN_TBL[size][off];
   endfunction

endpackage

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: request/response bus between the CPU load/store stage
// (master) and dmem_bus (slave).
//   req_valid/req_ready  request handshake
//   req_we, req_size, req_signed, addr, wdata  request payload
//   rsp_valid, rsp_rdata, rsp_err  response, one-cycle pulse
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. While req_ready is 0 the master keeps req_valid
// and the payload stable. Responses have no back-pressure: rsp_valid is
// a single-cycle pulse and rsp_rdata/rsp_err are 0 whenever it is low.
interface dmem_bus_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, addr, wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, addr, wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_bus.
//   size_i, off_i, signed_i  access size, addr[1:0], sign-extend select
//   wdata_i                  right-aligned store data
//   rword_i                  raw word read from the array
//   be_o                     store byte-enable mask
//   wdata_o                  store data replicated onto every lane
//   rdata_o                  load result, right-aligned and extended
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   always_comb begin
      be_o    = lane_en(size_i, off_i);
      wdata_o = 32'h0;
      rdata_o = 32'h0;
      // Move the addressed lane(s) down to bit 0; for legal half and word
      // accesses the offset is a multiple of the access size.
      shifted = rword_i >> {off_i, 3'b000};
      case (size_i)
         SZ_BYTE: begin
            // Replicating the data means be_o alone picks the target lane.
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         end
         SZ_WORD: begin
            wdata_o = wdata_i;
            rdata_o = shifted;
         end
         default: begin
            wdata_o = 32'h0;
            rdata_o = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_bus.sv
// dmem_bus: word-organised data memory behind a valid/ready request port.
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           dmem_bus_if slave: request handshake, payload, response
//   tap_byte      registered copy of word TAP_INDEX bits [7:0]
//   dbg_state_o   current FSM state
// Byte/half/word stores and loads with sign/zero extension, alignment and
// range faults, and 1- or 2-cycle load latency.
module dmem_bus
   import dmem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 2048,
   parameter int READ_LAT  = 1,
   parameter int TAP_INDEX = 1025
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_bus_if.slave  bus,
   output logic [7:0] tap_byte,
   output state_t     dbg_state_o
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int WIDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] TAP_IDX = IDX_W'(TAP_INDEX);

   logic [31:0] mem_q [DEPTH];

   state_t            state_q, state_d;
   logic              accept;
   logic [WIDX_W-1:0] widx;
   logic              range_err, req_err;

   // Request fields captured on the accept edge for the response phase.
   logic       we_q, sgn_q, err_q;
   logic [1:0] size_q, off_q;

   logic [31:0] rd1_q, rd2_q;
   logic        rsp_valid_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;
   logic [7:0]  tap_q;

   logic [1:0]  al_size, al_off;
   logic        al_sgn;
   logic [3:0]  be;
   logic [31:0] wdata_sh, ld_data;

   assign widx      = bus.addr[ADDR_W-1:2];
   assign range_err = (widx > WIDX_W'(DEPTH - 1));

   always_comb begin
      req_err = range_err;
      case (bus.req_size)
         SZ_HALF: req_err = range_err | bus.addr[0];
         SZ_WORD: req_err = range_err | (bus.addr[1:0] != 2'b00);
         SZ_RSVD: req_err = 1'b1;
         default: req_err = range_err;
      endcase
   end

   assign accept = bus.req_valid && (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = (!bus.req_we && !req_err && READ_LAT == 2) ? S_WAIT : S_RESP;
         S_WAIT: state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One aligner serves both directions: in IDLE it steers the incoming
   // store, afterwards it extracts the load from the captured fields.
   always_comb begin
      if (state_q == S_IDLE) begin
         al_size = bus.req_size;
         al_off  = bus.addr[1:0];
         al_sgn  = bus.req_signed;
      end else begin
         al_size = size_q;
         al_off  = off_q;
         al_sgn  = sgn_q;
      end
   end

   dmem_lane_align u_align (
      .size_i   (al_size),
      .off_i    (al_off),
      .signed_i (al_sgn),
      .wdata_i  (bus.wdata),
      .rword_i  ((READ_LAT == 2) ? rd2_q : rd1_q),
      .be_o     (be),
      .wdata_o  (wdata_sh),
      .rdata_o  (ld_data)
   );

   // Array and read pipeline are not reset. The read on the accept edge
   // sees every store accepted earlier, so back-to-back store/load to the
   // same word returns the new data.
   always_ff @(posedge clk) begin
      if (accept) rd1_q <= mem_q[widx[IDX_W-1:0]];
      rd2_q <= rd1_q;
      if (accept && bus.req_we && !req_err) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem_q[widx[IDX_W-1:0]][8*k +: 8] <= wdata_sh[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         sgn_q       <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= SZ_BYTE;
         off_q       <= 2'b00;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         tap_q       <= 8'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q   <= bus.req_we;
            sgn_q  <= bus.req_signed;
            err_q  <= req_err;
            size_q <= bus.req_size;
            off_q  <= bus.addr[1:0];
         end
         // The response registers load while leaving RESP, so the pulse
         // appears in the cycle after the RESP->IDLE edge.
         rsp_valid_q <= (state_q == S_RESP);
         if (state_q == S_RESP) begin
            rsp_err_q   <= err_q;
            rsp_rdata_q <= (we_q || err_q) ? 32'h0 : ld_data;
         end else begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
         end
         tap_q <= mem_q[TAP_IDX][7:0];
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign tap_byte      = tap_q;
   assign dbg_state_o   = state_q;

endmodule
